// File: rtl/popcount_nn_pkg.sv
// Shared definitions for the popcount-driven ternary neuron accumulators:
// default widths, controller state encoding and the saturating add.
package popcount_nn_pkg;

  localparam int CNT_W_DFLT     = 5;
  localparam int ACC_W_DFLT     = 10;
  localparam int MAX_BEATS_DFLT = 16;
  localparam int BEAT_W_DFLT    = 5;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  // Adds delta to acc and clamps to the signed range of an acc_w-bit word.
  // Done in 32-bit int so the intermediate can never wrap for acc_w < 31.
  function automatic int sat_add(input int acc, input int delta, input int acc_w);
    int hi;
    int lo;
    int s;
    hi = (1 << (acc_w - 1)) - 1;
    lo = -(1 << (acc_w - 1));
    s  = acc + delta;
    if (s > hi) begin
      sat_add = hi;
    end else if (s < lo) begin
      sat_add = lo;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/popcount_sat_add.sv
// Combinational step of the neuron: signed (pos - neg) popcount difference
// added to the running sum with saturation to the accumulator width.
module popcount_sat_add
  import popcount_nn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT,
  parameter int ACC_W = ACC_W_DFLT
) (
  input  logic        [CNT_W-1:0] pos_count_i,
  input  logic        [CNT_W-1:0] neg_count_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_next_o
);

  logic signed [CNT_W:0] delta;

  // Both counts are unsigned, so one extra bit holds the full signed difference.
  always_comb begin
    delta      = $signed({1'b0, pos_count_i}) - $signed({1'b0, neg_count_i});
    acc_next_o = ACC_W'(sat_add(int'(acc_i), int'(delta), ACC_W));
  end

endmodule

// File: rtl/popcount_neuron_acc.sv
// Multi-beat ternary neuron accumulator with threshold activation and a
// valid/ready result port. One bubble per neuron: no beat is accepted while
// a result is being presented.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   ST_ACC | accepting beats, summing pos-neg with saturation
//   ST_OUT | result held on out_* until out_ready
module popcount_neuron_acc
  import popcount_nn_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DFLT,
  parameter int ACC_W     = ACC_W_DFLT,
  parameter int MAX_BEATS = MAX_BEATS_DFLT,
  parameter int BEAT_W    = BEAT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [CNT_W-1:0] pos_count,
  input  logic [CNT_W-1:0] neg_count,
  input  logic [ACC_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overrun
);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic        [BEAT_W-1:0] beat_q;
  logic        [BEAT_W:0]   beat_inc;
  logic                     final_beat;
  logic        [ACC_W-1:0] out_sum_q;
  logic                    out_act_q;
  logic                    out_ovr_q;

  popcount_sat_add #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .pos_count_i (pos_count),
    .neg_count_i (neg_count),
    .acc_i       (acc_q),
    .acc_next_o  (acc_d)
  );

  // A beat ends the neuron on in_last or when it would be the MAX_BEATS-th.
  always_comb begin
    beat_inc   = {1'b0, beat_q} + (BEAT_W + 1)'(1);
    final_beat = in_last || (beat_inc == (BEAT_W + 1)'(MAX_BEATS));
  end

  // Controller, beat counter, accumulator and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      beat_q    <= '0;
      out_sum_q <= '0;
      out_act_q <= 1'b0;
      out_ovr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (final_beat) begin
              out_sum_q <= acc_d;
              out_act_q <= (acc_d >= $signed(threshold));
              out_ovr_q <= ~in_last;
              acc_q     <= '0;
              beat_q    <= '0;
              state_q   <= ST_OUT;
            end else begin
              acc_q  <= acc_d;
              beat_q <= beat_inc[BEAT_W-1:0];
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  // Handshake flags follow the state register directly.
  always_comb begin
    in_ready    = (state_q == ST_ACC);
    out_valid   = (state_q == ST_OUT);
    out_sum     = out_sum_q;
    out_act     = out_act_q;
    out_overrun = out_ovr_q;
  end

endmodule

// File: tb/tb_popcount_neuron_acc.sv
// Bench for popcount_neuron_acc: a default-size instance and a small
// instance (6-bit sum, 4 beats) that makes saturation and overrun reachable.
module tb_popcount_neuron_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
  logic [4:0] a_pos = 0, a_neg = 0;
  logic [9:0] a_thr = 0;
  logic       a_in_ready, a_out_valid, a_out_act, a_out_ovr;
  logic [9:0] a_out_sum;

  logic       b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
  logic [4:0] b_pos = 0, b_neg = 0;
  logic [5:0] b_thr = 0;
  logic       b_in_ready, b_out_valid, b_out_act, b_out_ovr;
  logic [5:0] b_out_sum;

  popcount_neuron_acc dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_last(a_in_last), .pos_count(a_pos), .neg_count(a_neg),
    .threshold(a_thr), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_act(a_out_act), .out_sum(a_out_sum), .out_overrun(a_out_ovr));

  popcount_neuron_acc #(.CNT_W(5), .ACC_W(6), .MAX_BEATS(4), .BEAT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_last(b_in_last), .pos_count(b_pos), .neg_count(b_neg),
    .threshold(b_thr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_act(b_out_act), .out_sum(b_out_sum), .out_overrun(b_out_ovr));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: each instance either holds a pending result or is summing.
  int m_busy[2]  = '{0, 0};
  int m_acc[2]   = '{0, 0};
  int m_beats[2] = '{0, 0};
  int m_sum[2]   = '{0, 0};
  int m_act[2]   = '{0, 0};
  int m_ovr[2]   = '{0, 0};

  task automatic mstep(input int k, input bit v, input int p, input int n, input bit l,
                       input int thr, input bit ordy, input int w, input int mb);
    int s, hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (m_busy[k] != 0) begin
      if (ordy) m_busy[k] = 0;
    end else if (v) begin
      s = m_acc[k] + p - n;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      m_beats[k]++;
      if (l || m_beats[k] == mb) begin
        m_sum[k]   = s;
        m_act[k]   = (s >= thr) ? 1 : 0;
        m_ovr[k]   = l ? 0 : 1;
        m_acc[k]   = 0;
        m_beats[k] = 0;
        m_busy[k]  = 1;
      end else begin
        m_acc[k] = s;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_acc[k] = 0; m_beats[k] = 0;
        m_sum[k] = 0; m_act[k] = 0; m_ovr[k] = 0;
      end
    end else begin
      mstep(0, a_in_valid, int'(a_pos), int'(a_neg), a_in_last, int'($signed(a_thr)),
            a_out_ready, 10, 16);
      mstep(1, b_in_valid, int'(b_pos), int'(b_neg), b_in_last, int'($signed(b_thr)),
            b_out_ready, 6, 4);
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready",  int'(a_in_ready),  (m_busy[0] != 0) ? 0 : 1);
    chk("a_out_valid", int'(a_out_valid), m_busy[0]);
    chk("a_out_sum",   int'($signed(a_out_sum)), m_sum[0]);
    chk("a_out_act",   int'(a_out_act),   m_act[0]);
    chk("a_out_ovr",   int'(a_out_ovr),   m_ovr[0]);
    chk("b_in_ready",  int'(b_in_ready),  (m_busy[1] != 0) ? 0 : 1);
    chk("b_out_valid", int'(b_out_valid), m_busy[1]);
    chk("b_out_sum",   int'($signed(b_out_sum)), m_sum[1]);
    chk("b_out_act",   int'(b_out_act),   m_act[1]);
    chk("b_out_ovr",   int'(b_out_ovr),   m_ovr[1]);
  end

  // Presents one beat and returns just after the edge that accepts it.
  task automatic send(input int k, input int p, input int n, input bit l, input int thr);
    int b;
    b = 0;
    @(negedge clk); #1;
    if (k == 0) begin
      a_in_valid = 1; a_pos = p[4:0]; a_neg = n[4:0]; a_in_last = l; a_thr = thr[9:0];
    end else begin
      b_in_valid = 1; b_pos = p[4:0]; b_neg = n[4:0]; b_in_last = l; b_thr = thr[5:0];
    end
    while (((k == 0) ? a_in_ready : b_in_ready) == 1'b0 && b < 40) begin
      @(negedge clk); #1;
      b++;
    end
    if (b >= 40) chk("send_timeout", b, 0);
    @(posedge clk); #1;
    if (k == 0) a_in_valid = 0; else b_in_valid = 0;
  endtask

  // Waits for a result and consumes it with a one-cycle out_ready pulse.
  task automatic pop(input int k);
    int b;
    b = 0;
    while (((k == 0) ? a_out_valid : b_out_valid) == 1'b0 && b < 40) begin
      @(negedge clk); #1;
      b++;
    end
    if (b >= 40) chk("pop_timeout", b, 0);
    @(negedge clk); #1;
    if (k == 0) a_out_ready = 1; else b_out_ready = 1;
    @(posedge clk); #1;
    if (k == 0) a_out_ready = 0; else b_out_ready = 0;
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    chk("rst_in_ready", int'(a_in_ready), 1);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_sum", int'($signed(a_out_sum)), 0);

    send(0, 10, 2, 0, 20); send(0, 5, 9, 0, 20); send(0, 19, 0, 1, 20);
    chk("t1_valid_next_cycle", int'(a_out_valid), 1);
    chk("t1_sum", int'($signed(a_out_sum)), 23);
    chk("t1_act", int'(a_out_act), 1);
    chk("t1_ovr", int'(a_out_ovr), 0);
    pop(0);

    send(0, 10, 2, 0, 24); send(0, 5, 9, 0, 24); send(0, 19, 0, 1, 24);
    chk("t2_sum", int'($signed(a_out_sum)), 23);
    chk("t2_act", int'(a_out_act), 0);
    pop(0);

    send(0, 0, 19, 1, -5);
    chk("t3_sum", int'($signed(a_out_sum)), -19);
    chk("t3_act", int'(a_out_act), 0);
    pop(0);

    send(0, 7, 3, 1, 0);
    a_in_valid = 1; a_pos = 5'd31; a_neg = 5'd0; a_in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", int'(a_out_valid), 1);
      chk("bp_in_ready", int'(a_in_ready), 0);
      chk("bp_sum", int'($signed(a_out_sum)), 4);
      chk("bp_act", int'(a_out_act), 1);
    end
    a_in_valid = 0; a_out_ready = 1;
    @(posedge clk); #1;
    a_out_ready = 0;
    chk("bp_release_in_ready", int'(a_in_ready), 1);
    chk("bp_release_valid", int'(a_out_valid), 0);
    send(0, 2, 0, 1, 0);
    chk("bp_fresh_sum", int'($signed(a_out_sum)), 2);
    pop(0);

    send(0, 4, 0, 0, 0); send(0, 4, 0, 0, 0);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_sum", int'($signed(a_out_sum)), 0);
    chk("arst_act", int'(a_out_act), 0);
    chk("arst_valid", int'(a_out_valid), 0);
    chk("arst_in_ready", int'(a_in_ready), 1);
    @(negedge clk); #1 rst = 0;
    send(0, 3, 1, 1, 0);
    chk("arst_new_sum", int'($signed(a_out_sum)), 2);
    pop(0);

    send(1, 31, 0, 0, 0); send(1, 31, 0, 0, 0); send(1, 31, 0, 0, 0);
    send(1, 0, 31, 1, 0);
    chk("sat_sum", int'($signed(b_out_sum)), 0);
    chk("sat_ovr", int'(b_out_ovr), 0);
    pop(1);

    for (int i = 0; i < 4; i++) send(1, 1, 0, 0, 0);
    chk("ovr_valid", int'(b_out_valid), 1);
    chk("ovr_sum", int'($signed(b_out_sum)), 4);
    chk("ovr_flag", int'(b_out_ovr), 1);
    pop(1);
    send(1, 1, 0, 0, 0); send(1, 2, 0, 1, 0);
    chk("ovr_next_sum", int'($signed(b_out_sum)), 3);
    chk("ovr_next_flag", int'(b_out_ovr), 0);
    pop(1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (i == 1500) begin
        #2 rst = 1;
        #4 rst = 0;
      end
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_last   = ($urandom_range(0, 7) == 0);
      a_pos       = 5'($urandom_range(0, 31));
      a_neg       = 5'($urandom_range(0, 31));
      a_thr       = 10'($urandom);
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_last   = ($urandom_range(0, 5) == 0);
      b_pos       = 5'($urandom_range(0, 31));
      b_neg       = 5'($urandom_range(0, 31));
      b_thr       = 6'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk); #1;
    a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
